// File: rtl/sha_arb_pkg.sv
// Shared types and sizing helpers for the SHA-256 core arbiter.
package sha_arb_pkg;

    localparam int unsigned BLOCK_W_DEF  = 512;
    localparam int unsigned DIGEST_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INIT    = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Index width for n items; never below one bit so single-bit ports stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sha_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching from the slot after pointer.
module rr_arbiter
    import sha_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    input  logic               enable,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   index,
    output logic               found
);

    int unsigned cand;

    always_comb begin
        winner = '0;
        index  = '0;
        found  = 1'b0;
        cand   = 0;
        if (enable) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = 32'(pointer) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (!found && req[cand[PTR_W-1:0]]) begin
                    found                     = 1'b1;
                    winner[cand[PTR_W-1:0]] = 1'b1;
                    index                     = cand[PTR_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/sha_arbiter.sv
// sha_arbiter: round-robin sharing of one SHA-256 core among NUM_REQ hash clients.
// Defining SHA_ARB_TIMEOUT_EN adds a WAIT watchdog and the timeout output port.
module sha_arbiter
    import sha_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned BLOCK_W  = BLOCK_W_DEF,
    parameter int unsigned DIGEST_W = DIGEST_W_DEF
`ifdef SHA_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*BLOCK_W-1:0]  req_block,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic [DIGEST_W-1:0]         digest,
    output logic                        busy,
    output logic                        sha_init,
    output logic                        sha_reset_n,
    output logic [BLOCK_W-1:0]          sha_block,
    input  logic                        sha_ready,
    input  logic [DIGEST_W-1:0]         sha_digest,
    input  logic                        sha_digest_valid
`ifdef SHA_ARB_TIMEOUT_EN
    ,
    output logic                        timeout
`endif
);

    localparam int unsigned PTR_W = clog2(NUM_REQ);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [PTR_W-1:0]     ptr;
    logic                 arb_en;
    logic [NUM_REQ-1:0]   arb_winner;
    logic [PTR_W-1:0]     arb_index;
    logic                 arb_found;
    logic                 start;
    logic                 finish;
    logic                 expire;

`ifdef SHA_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0]      wd_cnt;
`endif

    // A stale result still on the core output blocks new grants until it drops.
    assign arb_en = (state == IDLE) && sha_ready && !sha_digest_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req     (req),
        .pointer (ptr),
        .enable  (arb_en),
        .winner  (arb_winner),
        .index   (arb_index),
        .found   (arb_found)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    start      = 1'b1;
                    state_next = INIT;
                end
            end
            INIT: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (sha_digest_valid) begin
                    finish     = 1'b1;
                    state_next = RELEASE;
                end
`ifdef SHA_ARB_TIMEOUT_EN
                else if (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    expire     = 1'b1;
                    state_next = RELEASE;
                end
`endif
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant       <= '0;
            done        <= '0;
            digest      <= '0;
            sha_block   <= '0;
            sha_reset_n <= 1'b0;
            ptr         <= PTR_W'(NUM_REQ - 1);
        end else begin
            done        <= '0;
            sha_reset_n <= (state_next != RELEASE);
            if (start) begin
                grant     <= arb_winner;
                ptr       <= arb_index;
                sha_block <= req_block[32'(arb_index) * BLOCK_W +: BLOCK_W];
            end
            if (finish) begin
                digest <= sha_digest;
                done   <= grant;
            end
            if (expire) begin
                digest <= '0;
                done   <= grant;
            end
            if (state == RELEASE) begin
                grant <= '0;
            end
        end
    end

`ifdef SHA_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
            if (state == WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
`endif

    assign sha_init = (state == INIT);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sha_arbiter.sv
// Self-checking bench for sha_arbiter with a scripted core model and a round-robin reference.
// Build with SHA_ARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_sha_arbiter;

    localparam int N  = 3;
    localparam int BW = 512;
    localparam int DW = 256;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [N*BW-1:0]   req_block;
    logic [N-1:0]      grant;
    logic [N-1:0]      done;
    logic [DW-1:0]     digest;
    logic              busy;
    logic              sha_init;
    logic              sha_reset_n;
    logic [BW-1:0]     sha_block;
    logic              sha_ready;
    logic [DW-1:0]     sha_digest;
    logic              sha_digest_valid;
`ifdef SHA_ARB_TIMEOUT_EN
    logic              timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m;

    sha_arbiter #(
        .NUM_REQ  (N),
        .BLOCK_W  (BW),
        .DIGEST_W (DW)
`ifdef SHA_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .req_block        (req_block),
        .grant            (grant),
        .done             (done),
        .digest           (digest),
        .busy             (busy),
        .sha_init         (sha_init),
        .sha_reset_n      (sha_reset_n),
        .sha_block        (sha_block),
        .sha_ready        (sha_ready),
        .sha_digest       (sha_digest),
        .sha_digest_valid (sha_digest_valid)
`ifdef SHA_ARB_TIMEOUT_EN
        ,
        .timeout          (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: first requester strictly after the last winner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rand_digest();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic rand_blocks();
        for (int i = 0; i < N * BW / 32; i++) req_block[i*32 +: 32] = $urandom;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ptr_m   = N - 1;
        @(negedge clk);
    endtask

    // Full transaction from IDLE; leaves the bench at a negedge with the DUT back in IDLE.
    task automatic run_txn(input logic [N-1:0] r, input logic [N-1:0] r_wait,
                           input int lat, input logic [DW-1:0] d);
        int            w;
        logic [N-1:0]  exp_g;
        logic [BW-1:0] blk;
        w = rr_pick(r, ptr_m);
        if (w < 0) begin
            $display("FAIL txn_setup: request vector %b has no requester", r);
            n_fail++;
            return;
        end
        exp_g = '0;
        exp_g[w] = 1'b1;
        rand_blocks();
        blk = req_block[w*BW +: BW];
        req = r;
        @(negedge clk);
        n_checks++;
        if (grant !== exp_g) begin n_fail++; $display("FAIL txn_grant: got %b expected %b", grant, exp_g); end
        n_checks++;
        if (sha_init !== 1'b1) begin n_fail++; $display("FAIL txn_init_high: got %b expected 1", sha_init); end
        n_checks++;
        if (sha_block !== blk) begin n_fail++; $display("FAIL txn_block: got %h expected %h", sha_block, blk); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL txn_busy: got %b expected 1", busy); end
        ptr_m = w;
        rand_blocks();
        req_block[w*BW +: BW] = blk;
        req = r_wait;
        @(negedge clk);
        n_checks++;
        if (sha_init !== 1'b0) begin n_fail++; $display("FAIL txn_init_pulse: got %b expected 0", sha_init); end
        n_checks++;
        if (grant !== exp_g) begin n_fail++; $display("FAIL txn_grant_hold: got %b expected %b", grant, exp_g); end
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== '0) begin n_fail++; $display("FAIL txn_early_done: got %b expected 0", done); end
        end
        sha_digest       = d;
        sha_digest_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== exp_g) begin n_fail++; $display("FAIL txn_done: got %b expected %b", done, exp_g); end
        n_checks++;
        if (digest !== d) begin n_fail++; $display("FAIL txn_digest: got %h expected %h", digest, d); end
        n_checks++;
        if (sha_reset_n !== 1'b0) begin n_fail++; $display("FAIL txn_core_clear: got %b expected 0", sha_reset_n); end
        sha_digest_valid = 1'b0;
        sha_digest       = rand_digest();
        @(negedge clk);
        n_checks++;
        if (done !== '0) begin n_fail++; $display("FAIL txn_done_pulse: got %b expected 0", done); end
        n_checks++;
        if (grant !== '0) begin n_fail++; $display("FAIL txn_grant_clear: got %b expected 0", grant); end
        n_checks++;
        if (sha_reset_n !== 1'b1) begin n_fail++; $display("FAIL txn_core_release: got %b expected 1", sha_reset_n); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL txn_idle: got %b expected 0", busy); end
        n_checks++;
        if (sha_block !== blk) begin n_fail++; $display("FAIL txn_block_hold: got %h expected %h", sha_block, blk); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = N'($urandom);
        rand_blocks();
        repeat (2) @(negedge clk);
        n_checks++;
        if (grant !== '0) begin n_fail++; $display("FAIL rst_grant: got %b expected 0", grant); end
        n_checks++;
        if (done !== '0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_checks++;
        if (digest !== '0) begin n_fail++; $display("FAIL rst_digest: got %h expected 0", digest); end
        n_checks++;
        if (sha_init !== 1'b0) begin n_fail++; $display("FAIL rst_init: got %b expected 0", sha_init); end
        n_checks++;
        if (sha_block !== '0) begin n_fail++; $display("FAIL rst_block: got %h expected 0", sha_block); end
        n_checks++;
        if (sha_reset_n !== 1'b0) begin n_fail++; $display("FAIL rst_core_clear: got %b expected 0", sha_reset_n); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        req     = '0;
        reset_n = 1'b1;
        ptr_m   = N - 1;
        @(negedge clk);
        n_checks++;
        if (sha_reset_n !== 1'b1) begin n_fail++; $display("FAIL rst_core_release: got %b expected 1", sha_reset_n); end
    endtask

    task automatic test_single();
        run_txn(3'b001, 3'b000, 64, {8{32'hA5A5A5A5}});
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn(3'b011, 3'b011, $urandom_range(1, 8), rand_digest());
        end
    endtask

    task automatic test_withdraw();
        req = '0;
        @(negedge clk);
        run_txn(3'b010, 3'b000, 10, rand_digest());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== '0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL withdraw_no_regrant: grant %b busy %b expected 0 0", grant, busy);
            end
        end
    endtask

    task automatic test_stale_valid();
        sha_digest_valid = 1'b1;
        req = 3'b001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== '0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL stale_no_grant: grant %b busy %b expected 0 0", grant, busy);
            end
        end
        sha_digest_valid = 1'b0;
        sha_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== '0) begin n_fail++; $display("FAIL notready_no_grant: got %b expected 0", grant); end
        end
        sha_ready = 1'b1;
        run_txn(3'b001, 3'b000, 5, rand_digest());
    endtask

    task automatic test_reset_mid_wait();
        req = 3'b100;
        rand_blocks();
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_setup_busy: got %b expected 1", busy); end
        reset_n = 1'b0;
        req = '0;
        @(negedge clk);
        n_checks++;
        if (grant !== '0) begin n_fail++; $display("FAIL midrst_grant: got %b expected 0", grant); end
        n_checks++;
        if (sha_reset_n !== 1'b0) begin n_fail++; $display("FAIL midrst_core_clear: got %b expected 0", sha_reset_n); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        reset_n = 1'b1;
        ptr_m = N - 1;
        sha_digest = rand_digest();
        sha_digest_valid = 1'b1;
        @(negedge clk);
        sha_digest_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (done !== '0) begin n_fail++; $display("FAIL midrst_no_done: got %b expected 0", done); end
            @(negedge clk);
        end
        run_txn(3'b111, 3'b000, 3, rand_digest());
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        for (int t = 0; t < 20; t++) begin
            req = '0;
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                @(negedge clk);
                n_checks++;
                if (grant !== '0) begin n_fail++; $display("FAIL rand_idle_grant: got %b expected 0", grant); end
            end
            r = N'($urandom_range(1, (1 << N) - 1));
            run_txn(r, r & N'($urandom), $urandom_range(0, 20), rand_digest());
        end
        req = '0;
    endtask

`ifdef SHA_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int           w;
        logic [N-1:0] exp_g;
        req = 3'b011;
        w = rr_pick(req, ptr_m);
        exp_g = '0;
        exp_g[w] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (grant !== exp_g) begin n_fail++; $display("FAIL to_grant: got %b expected %b", grant, exp_g); end
        ptr_m = w;
        req = '0;
        @(negedge clk);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== '0 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL to_early: done %b timeout %b at wait cycle %0d", done, timeout, i + 1);
            end
        end
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", timeout); end
        n_checks++;
        if (done !== exp_g) begin n_fail++; $display("FAIL to_done: got %b expected %b", done, exp_g); end
        n_checks++;
        if (digest !== '0) begin n_fail++; $display("FAIL to_digest: got %h expected 0", digest); end
        n_checks++;
        if (sha_reset_n !== 1'b0) begin n_fail++; $display("FAIL to_core_clear: got %b expected 0", sha_reset_n); end
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b0 || grant !== '0) begin
            n_fail++; $display("FAIL to_release: timeout %b grant %b expected 0 0", timeout, grant);
        end
    endtask
`endif

    initial begin
        reset_n          = 1'b0;
        req              = '0;
        req_block        = '0;
        sha_ready        = 1'b1;
        sha_digest       = '0;
        sha_digest_valid = 1'b0;
        ptr_m            = N - 1;
        test_reset();
        test_single();
        test_contention();
        test_withdraw();
        test_stale_valid();
        test_reset_mid_wait();
        test_random();
`ifdef SHA_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
